pipe_bypass_ctrl: RTL and testbench

Parametrised operand-bypass and interlock controller for the in-order LoongArch pipeline, sitting between decode and the regfile/ALU datapath. It tracks destination tags and results of every in-flight instruction across NSTAGE post-decode stages (default EX, MEM, WB), returns forwarded source operands to decode, raises a load-use stall, and drives the regfile write port from the last stage. It replaces hand-written per-stage forwarding compares with a generalised, depth-configurable structure.

---
 rtl/pipe_bypass_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_bypass_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_bypass_ctrl.sv
// pipe_bypass_ctrl: operand bypass and load-use interlock across NSTAGE post-decode stages.
// Define PIPE_BYPASS_EN for full forwarding; without it the block is interlock-only.
module pipe_bypass_ctrl #(
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 1,
    parameter int DW         = 32,
    parameter int AW         = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    input  logic          flush,
    input  logic          id_valid,
    input  logic          id_we,
    input  logic [AW-1:0] id_dest,
    input  logic          id_late,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    input  logic [DW-1:0] ex_data,
    input  logic [DW-1:0] ld_data,
    output logic [DW-1:0] src1_data,
    output logic [DW-1:0] src2_data,
    output logic          id_stall,
    output logic          issue,
    output logic          wb_we,
    output logic [AW-1:0] wb_dest,
    output logic [DW-1:0] wb_data
);

    logic          v_q    [NSTAGE];
    logic          we_q   [NSTAGE];
    logic          late_q [NSTAGE];
    logic [AW-1:0] dest_q [NSTAGE];
    logic [DW-1:0] data_q [NSTAGE];

    logic          v_d    [NSTAGE];
    logic          we_d   [NSTAGE];
    logic          late_d [NSTAGE];
    logic [AW-1:0] dest_d [NSTAGE];
    logic [DW-1:0] data_d [NSTAGE];

    logic [DW-1:0] eff    [NSTAGE];
    logic          hit1;
    logic          hit2;

`ifdef PIPE_BYPASS_EN
    logic          rdy_q  [NSTAGE];
    logic          rdy_d  [NSTAGE];
    logic          rdy_e  [NSTAGE];
    logic          rdy1;
    logic          rdy2;
`endif

    assign issue = id_valid & adv & ~id_stall & ~flush;

    // Results still travel down the pipe so the last stage can write the regfile.
    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            eff[k] = data_q[k];
            if (k == 0 && !late_q[k]) eff[k] = ex_data;
            if (k == LOAD_STAGE && late_q[k]) eff[k] = ld_data;
`ifdef PIPE_BYPASS_EN
            rdy_e[k] = rdy_q[k]
                     | (k == 0 && !late_q[k])
                     | (k == LOAD_STAGE && late_q[k]);
`endif
        end
    end

    always_comb begin
        v_d[0]    = issue;
        we_d[0]   = issue & id_we & (id_dest != '0);
        late_d[0] = issue & id_late;
        dest_d[0] = issue ? id_dest : '0;
        data_d[0] = '0;
`ifdef PIPE_BYPASS_EN
        rdy_d[0]  = 1'b0;
`endif
        for (int k = 1; k < NSTAGE; k++) begin
            v_d[k]    = v_q[k-1];
            we_d[k]   = we_q[k-1];
            late_d[k] = late_q[k-1];
            dest_d[k] = dest_q[k-1];
            data_d[k] = eff[k-1];
`ifdef PIPE_BYPASS_EN
            rdy_d[k]  = rdy_e[k-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                v_q[k]    <= 1'b0;
                we_q[k]   <= 1'b0;
                late_q[k] <= 1'b0;
                dest_q[k] <= '0;
                data_q[k] <= '0;
`ifdef PIPE_BYPASS_EN
                rdy_q[k]  <= 1'b0;
`endif
            end
        end else if (adv) begin
            for (int k = 0; k < NSTAGE; k++) begin
                v_q[k]    <= v_d[k];
                we_q[k]   <= we_d[k];
                late_q[k] <= late_d[k];
                dest_q[k] <= dest_d[k];
                data_q[k] <= data_d[k];
`ifdef PIPE_BYPASS_EN
                rdy_q[k]  <= rdy_d[k];
`endif
            end
        end
    end

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
`ifdef PIPE_BYPASS_EN
        rdy1      = 1'b0;
        rdy2      = 1'b0;
        src1_data = rf_rdata1;
        src2_data = rf_rdata2;
`endif
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (v_q[k] && we_q[k] && id_rs1 != '0 && dest_q[k] == id_rs1) begin
                hit1 = 1'b1;
`ifdef PIPE_BYPASS_EN
                rdy1      = rdy_e[k];
                src1_data = eff[k];
`endif
            end
            if (v_q[k] && we_q[k] && id_rs2 != '0 && dest_q[k] == id_rs2) begin
                hit2 = 1'b1;
`ifdef PIPE_BYPASS_EN
                rdy2      = rdy_e[k];
                src2_data = eff[k];
`endif
            end
        end
    end

`ifdef PIPE_BYPASS_EN
    assign id_stall = id_valid & ((hit1 & ~rdy1) | (hit2 & ~rdy2));
`else
    assign src1_data = rf_rdata1;
    assign src2_data = rf_rdata2;
    assign id_stall  = id_valid & (hit1 | hit2);
`endif

    assign wb_we   = v_q[NSTAGE-1] & we_q[NSTAGE-1];
    assign wb_dest = dest_q[NSTAGE-1];
    assign wb_data = data_q[NSTAGE-1];

endmodule

// File: tb/tb_pipe_bypass_ctrl.sv
// tb_pipe_bypass_ctrl: directed checks of forwarding, interlock, freeze, flush and reset.
// Expectations cover both the PIPE_BYPASS_EN and interlock-only builds.
module tb_pipe_bypass_ctrl;

`ifdef PIPE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] RF1 = 32'h1111_0001;
    localparam logic [31:0] RF2 = 32'h2222_0002;

    logic        clk = 1'b0;
    logic        reset, adv, flush;
    logic        id_valid, id_we, id_late;
    logic [4:0]  id_dest, id_rs1, id_rs2;
    logic [31:0] rf_rdata1, rf_rdata2, ex_data, ld_data;
    logic [31:0] src1_data, src2_data, wb_data;
    logic        id_stall, issue, wb_we;
    logic [4:0]  wb_dest;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_bypass_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .adv       (adv),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_we     (id_we),
        .id_dest   (id_dest),
        .id_late   (id_late),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .ex_data   (ex_data),
        .ld_data   (ld_data),
        .src1_data (src1_data),
        .src2_data (src2_data),
        .id_stall  (id_stall),
        .issue     (issue),
        .wb_we     (wb_we),
        .wb_dest   (wb_dest),
        .wb_data   (wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic we, input logic [4:0] d,
                         input logic late, input logic [4:0] r1,
                         input logic [4:0] r2);
        id_valid = v;
        id_we    = we;
        id_dest  = d;
        id_late  = late;
        id_rs1   = r1;
        id_rs2   = r2;
        #1;
    endtask

    initial begin
        reset = 1'b1; adv = 1'b1; flush = 1'b0;
        rf_rdata1 = RF1; rf_rdata2 = RF2;
        ex_data = '0; ld_data = '0;
        instr(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // reset state
        chk("rst_wb_we",    wb_we,     0);
        chk("rst_wb_dest",  wb_dest,   0);
        chk("rst_wb_data",  wb_data,   0);
        chk("rst_stall",    id_stall,  0);
        chk("rst_issue",    issue,     0);
        chk("rst_src1",     src1_data, RF1);
        chk("rst_src2",     src2_data, RF2);

        // back-to-back ALU on r4
        instr(1, 1, 4, 0, 1, 2);
        chk("alu_prod_issue", issue, 1);
        tick();
        ex_data = 32'h11;
        instr(1, 0, 0, 0, 4, 0);
        chk("alu_src1",  src1_data, BYP ? 32'h11 : RF1);
        chk("alu_stall", id_stall,  BYP ? 0 : 1);
        chk("alu_issue", issue,     BYP ? 1 : 0);
        tick();
        ex_data = 32'h99;
        instr(0, 0, 0, 0, 0, 0);
        tick();
        chk("alu_wb_we",   wb_we,   1);
        chk("alu_wb_dest", wb_dest, 4);
        chk("alu_wb_data", wb_data, 32'h11);
        tick();
        chk("alu_wb_off",  wb_we,   0);

        // load-use on r5
        instr(1, 1, 5, 1, 0, 0);
        chk("ld_prod_issue", issue, 1);
        tick();
        instr(1, 0, 0, 0, 0, 5);
        chk("ld_stall0", id_stall, 1);
        chk("ld_issue0", issue,    0);
        tick();
        ld_data = 32'hDEAD;
        #1;
        chk("ld_stall1", id_stall,  BYP ? 0 : 1);
        chk("ld_issue1", issue,     BYP ? 1 : 0);
        chk("ld_src2",   src2_data, BYP ? 32'hDEAD : RF2);
        tick();
        ld_data = 32'hBEEF;
        #1;
        chk("ld_wb_we",   wb_we,     1);
        chk("ld_wb_dest", wb_dest,   5);
        chk("ld_wb_data", wb_data,   32'hDEAD);
        chk("ld_stall2",  id_stall,  BYP ? 0 : 1);
        chk("ld_src2_wb", src2_data, BYP ? 32'hDEAD : RF2);
        tick();
        chk("ld_stall3",  id_stall,  0);
        chk("ld_issue3",  issue,     1);
        chk("ld_src2_rf", src2_data, RF2);
        instr(0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();

        // youngest-match priority on r6
        instr(1, 1, 6, 0, 0, 0);
        tick();
        ex_data = 32'hA;
        instr(1, 0, 0, 0, 0, 0);
        tick();
        instr(1, 1, 6, 0, 0, 0);
        tick();
        ex_data = 32'hB;
        instr(1, 0, 0, 0, 6, 6);
        chk("pri_src1",    src1_data, BYP ? 32'hB : RF1);
        chk("pri_src2",    src2_data, BYP ? 32'hB : RF2);
        chk("pri_stall",   id_stall,  BYP ? 0 : 1);
        chk("pri_wb_dest", wb_dest,   6);
        chk("pri_wb_data", wb_data,   32'hA);
        tick();
        instr(0, 0, 0, 0, 0, 0);
        tick();
        chk("pri_wb2_we",   wb_we,   1);
        chk("pri_wb2_data", wb_data, 32'hB);
        tick();

        // r0 guard
        ex_data = 32'h77;
        instr(1, 1, 0, 0, 0, 0);
        tick();
        instr(1, 0, 0, 0, 0, 0);
        chk("r0_stall", id_stall,  0);
        chk("r0_src1",  src1_data, RF1);
        chk("r0_src2",  src2_data, RF2);
        tick();
        instr(0, 0, 0, 0, 0, 0);
        tick();
        chk("r0_wb_we", wb_we, 0);
        tick();
        tick();

        // freeze with an entry at writeback
        instr(1, 1, 9, 0, 0, 0);
        tick();
        ex_data = 32'h55;
        instr(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        adv = 1'b0;
        instr(1, 1, 3, 0, 0, 0);
        chk("frz_issue", issue, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_wb_we",   wb_we,   1);
            chk("frz_wb_dest", wb_dest, 9);
            chk("frz_wb_data", wb_data, 32'h55);
        end
        adv = 1'b1;
        instr(0, 0, 0, 0, 0, 0);
        tick();
        chk("frz_resume_we", wb_we, 0);

        // flush turns the decode instruction into a bubble
        flush = 1'b1;
        instr(1, 1, 8, 0, 0, 0);
        chk("fl_issue", issue, 0);
        tick();
        flush = 1'b0;
        instr(1, 0, 0, 0, 8, 0);
        chk("fl_no_stall", id_stall,  0);
        chk("fl_src1",     src1_data, RF1);
        instr(1, 1, 10, 0, 0, 0);
        tick();
        flush = 1'b1;
        instr(1, 0, 0, 0, 10, 0);
        chk("fl_dep_stall", id_stall, BYP ? 0 : 1);
        chk("fl_dep_issue", issue,    0);
        flush = 1'b0;
        instr(0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();

        // reset with three entries in flight
        instr(1, 1, 11, 0, 0, 0);
        tick();
        instr(1, 1, 12, 0, 0, 0);
        tick();
        instr(1, 1, 13, 0, 0, 0);
        tick();
        instr(1, 0, 0, 0, 13, 0);
        chk("rmf_wb_we",   wb_we,    1);
        chk("rmf_wb_dest", wb_dest,  11);
        chk("rmf_stall",   id_stall, BYP ? 0 : 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rmf_post_we",    wb_we,    0);
        chk("rmf_post_stall", id_stall, 0);
        chk("rmf_post_issue", issue,    1);
        tick();
        instr(0, 0, 0, 0, 0, 0);
        chk("rmf_we1", wb_we, 0);
        tick();
        chk("rmf_we2", wb_we, 0);
        tick();
        chk("rmf_we3", wb_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
